// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-deep holding register for back-to-back frames.
// All outputs are registered; status flags are sticky until cleared by the host.
module uart_tx #(
    parameter int unsigned BAUD_CLKS = 43,
    parameter int unsigned BAUD_W    = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    input  logic       clr_done,
    output logic       TX,
    output logic       busy,
    output logic       tx_done,
    output logic       hold_full,
    output logic       overrun
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_CLKS - 1);

    state_t            state, state_n;
    logic [BAUD_W-1:0] baud_cnt, baud_cnt_n;
    logic [2:0]        bit_cnt, bit_cnt_n;
    logic [7:0]        shift_reg, shift_n;
    logic [7:0]        hold_reg, hold_n;
    logic              hold_full_n, tx_n, busy_n, tx_done_n, overrun_n;
    logic              bit_end, frame_end;

    assign bit_end = (baud_cnt == BAUD_LAST);

    always_comb begin
        state_n     = state;
        baud_cnt_n  = bit_end ? '0 : baud_cnt + 1'b1;
        bit_cnt_n   = bit_cnt;
        shift_n     = shift_reg;
        hold_n      = hold_reg;
        hold_full_n = hold_full;
        tx_n        = TX;
        tx_done_n   = tx_done;
        overrun_n   = overrun;
        frame_end   = 1'b0;

        // Clears are applied first so that any set below takes priority.
        if (clr_done) begin
            tx_done_n = 1'b0;
            overrun_n = 1'b0;
        end

        case (state)
            IDLE: begin
                baud_cnt_n = '0;
                bit_cnt_n  = '0;
                tx_n       = 1'b1;
                if (trmt) begin
                    shift_n   = tx_data;
                    state_n   = START;
                    tx_n      = 1'b0;
                    tx_done_n = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_n   = DATA;
                    bit_cnt_n = '0;
                    tx_n      = shift_reg[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_cnt == 3'd7) begin
                        state_n = STOP;
                        tx_n    = 1'b1;
                    end else begin
                        shift_n   = shift_reg >> 1;
                        tx_n      = shift_reg[1];
                        bit_cnt_n = bit_cnt + 3'd1;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    frame_end = 1'b1;
                    tx_done_n = 1'b1;
                    if (hold_full) begin
                        // Queued byte goes out next; a same-cycle trmt refills the hold.
                        shift_n     = hold_reg;
                        state_n     = START;
                        tx_n        = 1'b0;
                        hold_full_n = trmt;
                        if (trmt) hold_n = tx_data;
                    end else if (trmt) begin
                        shift_n = tx_data;
                        state_n = START;
                        tx_n    = 1'b0;
                    end else begin
                        state_n = IDLE;
                        tx_n    = 1'b1;
                    end
                end
            end
            default: begin
                state_n    = IDLE;
                tx_n       = 1'b1;
                baud_cnt_n = '0;
                bit_cnt_n  = '0;
            end
        endcase

        if (trmt && (state != IDLE) && !frame_end) begin
            if (!hold_full) begin
                hold_n      = tx_data;
                hold_full_n = 1'b1;
            end else begin
                overrun_n = 1'b1;
            end
        end

        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            hold_reg  <= '0;
            hold_full <= 1'b0;
            TX        <= 1'b1;
            busy      <= 1'b0;
            tx_done   <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_n;
            baud_cnt  <= baud_cnt_n;
            bit_cnt   <= bit_cnt_n;
            shift_reg <= shift_n;
            hold_reg  <= hold_n;
            hold_full <= hold_full_n;
            TX        <= tx_n;
            busy      <= busy_n;
            tx_done   <= tx_done_n;
            overrun   <= overrun_n;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: frame timing, queuing, overrun, collisions, reset and
// a behavioural receiver decoding the serial line.
module tb_uart_tx;

    localparam int BC    = 43;
    localparam int FRAME = 10 * BC;

    logic       clk = 1'b0;
    logic       rst_n, trmt, clr_done;
    logic [7:0] tx_data;
    logic       TX, busy, tx_done, hold_full, overrun;

    int         n_vec = 0;
    int         n_err = 0;
    int         rx_cnt = 0;
    logic [7:0] rx_byte = '0;

    uart_tx #(.BAUD_CLKS(43), .BAUD_W(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .trmt      (trmt),
        .tx_data   (tx_data),
        .clr_done  (clr_done),
        .TX        (TX),
        .busy      (busy),
        .tx_done   (tx_done),
        .hold_full (hold_full),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Start a frame from IDLE; returns at the first cycle TX should be low.
    task automatic send(input logic [7:0] d);
        trmt    = 1'b1;
        tx_data = d;
        @(negedge clk);
        trmt = 1'b0;
    endtask

    // Follows a frame from cycle n0 through cycle FRAME, checking TX and busy at the
    // first and last cycle of every bit; returns at cycle FRAME+1.
    task automatic watch(input string tag, input logic [7:0] d, input int n0,
                         input int trig_at, input logic [7:0] td, input int clr_at,
                         input logic exp_hold);
        logic exp_bit;
        for (int n = n0; n <= FRAME; n++) begin
            int b;
            int ph;
            trmt     = 1'b0;
            clr_done = 1'b0;
            if (n == trig_at) begin
                trmt    = 1'b1;
                tx_data = td;
            end
            if (n == clr_at) clr_done = 1'b1;
            b  = (n - 1) / BC;
            ph = (n - 1) % BC;
            if (b == 0)      exp_bit = 1'b0;
            else if (b == 9) exp_bit = 1'b1;
            else             exp_bit = d[b-1];
            if (ph == 0 || ph == BC - 1) begin
                check({tag, "_tx"}, 32'(TX), 32'(exp_bit));
                check({tag, "_busy"}, 32'(busy), 32'd1);
            end
            if (n == FRAME) check({tag, "_hold_end"}, 32'(hold_full), 32'(exp_hold));
            @(negedge clk);
        end
        trmt     = 1'b0;
        clr_done = 1'b0;
    endtask

    // Behavioural receiver: mid-bit sampling of the serial line.
    initial begin
        logic [7:0] sh;
        logic       ok;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && TX === 1'b0) begin
                repeat (BC / 2) @(negedge clk);
                ok = (TX === 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (BC) @(negedge clk);
                    sh[i] = TX;
                end
                repeat (BC) @(negedge clk);
                if (ok && TX === 1'b1) begin
                    rx_byte = sh;
                    rx_cnt++;
                end
            end
        end
    end

    initial begin
        logic [7:0] lb_vals [3];
        rst_n    = 1'b0;
        trmt     = 1'b0;
        clr_done = 1'b0;
        tx_data  = '0;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(TX), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(tx_done), 32'd0);
        check("rst_hold", 32'(hold_full), 32'd0);
        check("rst_ovr", 32'(overrun), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single byte
        send(8'hA5);
        watch("a5", 8'hA5, 1, 0, '0, 0, 1'b0);
        check("a5_busy_end", 32'(busy), 32'd0);
        check("a5_done", 32'(tx_done), 32'd1);
        check("a5_tx_idle", 32'(TX), 32'd1);
        repeat (5) @(negedge clk);
        check("a5_done_sticky", 32'(tx_done), 32'd1);
        clr_done = 1'b1;
        @(negedge clk);
        clr_done = 1'b0;
        check("a5_done_clr", 32'(tx_done), 32'd0);
        repeat (3) @(negedge clk);

        // Back-to-back via the holding register
        send(8'h55);
        watch("b2b0", 8'h55, 1, 100, 8'h0F, 0, 1'b1);
        check("b2b_busy_mid", 32'(busy), 32'd1);
        check("b2b_done1", 32'(tx_done), 32'd1);
        check("b2b_hold_clr", 32'(hold_full), 32'd0);
        watch("b2b1", 8'h0F, 1, 0, '0, 10, 1'b0);
        check("b2b_busy_end", 32'(busy), 32'd0);
        check("b2b_done2", 32'(tx_done), 32'd1);
        repeat (3) @(negedge clk);

        // Overrun: three trmts on consecutive cycles
        trmt    = 1'b1;
        tx_data = 8'h11;
        @(negedge clk);
        tx_data = 8'h22;
        @(negedge clk);
        tx_data = 8'h33;
        @(negedge clk);
        trmt = 1'b0;
        check("ovr_set", 32'(overrun), 32'd1);
        check("ovr_hold", 32'(hold_full), 32'd1);
        check("ovr_done_acc", 32'(tx_done), 32'd0);
        watch("ovr0", 8'h11, 3, 0, '0, FRAME, 1'b1);
        check("ovr_done_setwins", 32'(tx_done), 32'd1);
        check("ovr_clr", 32'(overrun), 32'd0);
        watch("ovr1", 8'h22, 1, 0, '0, 0, 1'b0);
        check("ovr_busy_end", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);

        // Frame-end collision, hold empty
        send(8'h96);
        watch("col0", 8'h96, 1, FRAME, 8'h69, 0, 1'b0);
        check("col_busy", 32'(busy), 32'd1);
        check("col_hold", 32'(hold_full), 32'd0);
        watch("col1", 8'h69, 1, 0, '0, 0, 1'b0);
        check("col_busy_end", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);

        // Frame-end collision, hold full
        trmt    = 1'b1;
        tx_data = 8'h81;
        @(negedge clk);
        tx_data = 8'h42;
        @(negedge clk);
        trmt = 1'b0;
        watch("colh0", 8'h81, 2, FRAME, 8'h24, 0, 1'b1);
        check("colh_hold", 32'(hold_full), 32'd1);
        check("colh_ovr", 32'(overrun), 32'd0);
        watch("colh1", 8'h42, 1, 0, '0, 0, 1'b1);
        check("colh_hold2", 32'(hold_full), 32'd0);
        watch("colh2", 8'h24, 1, 0, '0, 0, 1'b0);
        check("colh_busy_end", 32'(busy), 32'd0);
        check("colh_ovr_end", 32'(overrun), 32'd0);
        repeat (3) @(negedge clk);

        // Reset mid-frame with a byte queued
        send(8'hE7);
        repeat (49) @(negedge clk);
        trmt    = 1'b1;
        tx_data = 8'h5A;
        @(negedge clk);
        trmt = 1'b0;
        check("rmf_hold", 32'(hold_full), 32'd1);
        repeat (149) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("rmf_tx", 32'(TX), 32'd1);
        check("rmf_busy", 32'(busy), 32'd0);
        check("rmf_hold_clr", 32'(hold_full), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        send(8'hC3);
        watch("c3", 8'hC3, 1, 0, '0, 0, 1'b0);
        check("c3_busy_end", 32'(busy), 32'd0);
        check("c3_done", 32'(tx_done), 32'd1);
        repeat (500) @(negedge clk);

        // Loopback through the behavioural receiver
        lb_vals[0] = 8'h00;
        lb_vals[1] = 8'hFF;
        lb_vals[2] = 8'h3C;
        for (int k = 0; k < 3; k++) begin
            int c0;
            int t;
            c0 = rx_cnt;
            send(lb_vals[k]);
            t = 0;
            while (rx_cnt == c0 && t < 600) begin
                @(negedge clk);
                t++;
            end
            check("lb_rdy", 32'(rx_cnt != c0), 32'd1);
            check("lb_data", 32'(rx_byte), 32'(lb_vals[k]));
            repeat (60) @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
